// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: key-schedule constants, FSM encoding, rotate amounts and word helpers.
package sm4_pkg;

  localparam int unsigned NROUND = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned KEY_W  = 128;

  localparam logic [WORD_W-1:0] FK0 = 32'hA3B1BAC6;
  localparam logic [WORD_W-1:0] FK1 = 32'h56AA3350;
  localparam logic [WORD_W-1:0] FK2 = 32'h677D9197;
  localparam logic [WORD_W-1:0] FK3 = 32'hB27022DC;

  // L' (key schedule) and L (round datapath) rotate amounts
  localparam int unsigned LP_ROT_A = 13;
  localparam int unsigned LP_ROT_B = 23;
  localparam int unsigned L_ROT_A  = 2;
  localparam int unsigned L_ROT_B  = 10;
  localparam int unsigned L_ROT_C  = 18;
  localparam int unsigned L_ROT_D  = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] k0;
    logic [WORD_W-1:0] k1;
    logic [WORD_W-1:0] k2;
    logic [WORD_W-1:0] k3;
  } key_state_t;

  function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/sm4_ck.sv
// SM4 CK constant for a round index: byte j of CK[i] is (4*i + j) * 7 mod 256.
module sm4_ck
  import sm4_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] ck_c
);

  always_comb begin
    ck_c = '0;
    for (int j = 0; j < 4; j++) begin
      ck_c[WORD_W-1-8*j -: 8] = 8'((8'({idx, 2'b00}) + 8'(j)) * 8'd7);
    end
  end

endmodule

// File: rtl/sm4_key_tprime.sv
// Key-schedule T' transform: byte-wise S-box substitution followed by L'.
module sm4_key_tprime
  import sm4_pkg::*;
(
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout_c
);

  logic [WORD_W-1:0] sub;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sm4_sbox u_sbox (
      .din    (din[8*g +: 8]),
      .dout_c (sub[8*g +: 8])
    );
  end

  assign dout_c = sub ^ rotl32(sub, LP_ROT_A) ^ rotl32(sub, LP_ROT_B);

endmodule

// File: rtl/sm4_sbox.sv
// SM4 8-bit S-box, purely combinational lookup.
module sm4_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout_c
);

  localparam logic [7:0] SBOX_TAB [256] = '{
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };

  assign dout_c = SBOX_TAB[din];

endmodule

// File: rtl/sm4_key_sched.sv
// Iterative SM4 key expansion: one round key per cycle into a 32-entry register file,
// read back by index in encryption or reversed (decryption) order.
module sm4_key_sched
  import sm4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              key_start,
  output logic              busy,
  output logic              rk_valid,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              rd_dec,
  output logic [WORD_W-1:0] rd_key
);

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  key_state_t        ks;
  logic [WORD_W-1:0] ck_val;
  logic [WORD_W-1:0] tp_in;
  logic [WORD_W-1:0] tp_out;
  logic [WORD_W-1:0] rk_next;
  logic [WORD_W-1:0] rf [NROUND];
  logic [IDX_W-1:0]  rd_sel;

  sm4_ck u_ck (
    .idx  (cnt),
    .ck_c (ck_val)
  );

  assign tp_in = ks.k1 ^ ks.k2 ^ ks.k3 ^ ck_val;

  sm4_key_tprime u_tprime (
    .din    (tp_in),
    .dout_c (tp_out)
  );

  assign rk_next = ks.k0 ^ tp_out;

  // Control FSM and K0..K3 sliding window; key_start is ignored while expanding
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      cnt      <= '0;
      ks       <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_READY: begin
          if (key_start) begin
            state    <= ST_EXPAND;
            busy     <= 1'b1;
            rk_valid <= 1'b0;
            cnt      <= '0;
            ks       <= '{k0: key_in[127:96] ^ FK0,
                          k1: key_in[95:64]  ^ FK1,
                          k2: key_in[63:32]  ^ FK2,
                          k3: key_in[31:0]   ^ FK3};
          end
        end
        ST_EXPAND: begin
          ks <= '{k0: ks.k1, k1: ks.k2, k2: ks.k3, k3: rk_next};
          if (cnt == IDX_W'(NROUND - 1)) begin
            state    <= ST_READY;
            busy     <= 1'b0;
            rk_valid <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          rk_valid <= 1'b0;
        end
      endcase
    end
  end

  // Round-key storage; contents are only meaningful while rk_valid is high
  always_ff @(posedge clk) begin
    if (state == ST_EXPAND) begin
      rf[cnt] <= rk_next;
    end
  end

  assign rd_sel = rd_dec ? ~rd_idx : rd_idx;
  assign rd_key = rf[rd_sel];

endmodule
